rv_iopmp_match_engine: RTL and testbench

- Parametrised IOPMP transaction checker.
- Accepts one transaction request (SID, base address, byte length, access type) through a valid/ready handshake.
- Scans the entry table ENTRIES_PER_CYCLE entries per cycle over a pipelined 1-cycle-latency read port, using static priority: the lowest-index matching entry decides.
- Returns allow/deny plus error-capture data. Sits between the IOPMP bus front-end and the entry/MD register file.

---
 rtl/rv_iopmp_match_engine_if.sv | 37 +++
 rtl/rv_iopmp_match_engine.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_rv_iopmp_match_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_iopmp_match_engine_if.sv
// Request / response / error-capture bundle of the IOPMP match engine.
// The engine sits on the slave side; the bus front-end drives the master side.
interface rv_iopmp_match_engine_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int SID_WIDTH  = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int EID_WIDTH  = 3
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [SID_WIDTH-1:0]  req_sid_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [LEN_WIDTH-1:0]  req_len_i;
    logic [1:0]            req_access_i;

    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic                  resp_allow_o;
    logic [2:0]            resp_etype_o;
    logic [EID_WIDTH-1:0]  resp_eid_o;

    logic                  err_valid_o;
    logic [SID_WIDTH-1:0]  err_sid_o;
    logic [ADDR_WIDTH-1:0] err_addr_o;

    modport slave (
        input  req_valid_i, req_sid_i, req_addr_i, req_len_i, req_access_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_allow_o, resp_etype_o, resp_eid_o,
               err_valid_o, err_sid_o, err_addr_o
    );

    modport master (
        output req_valid_i, req_sid_i, req_addr_i, req_len_i, req_access_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_allow_o, resp_etype_o, resp_eid_o,
               err_valid_o, err_sid_o, err_addr_o
    );
endinterface

// File: rtl/rv_iopmp_match_engine.sv
// IOPMP transaction checker: accepts one request, scans the entry table
// K entries per cycle through a 1-cycle-latency read port, and reports
// allow/deny from the lowest-index matching entry plus error-capture data.
module rv_iopmp_match_engine #(
    parameter int ADDR_WIDTH        = 64,
    parameter int SID_WIDTH         = 8,
    parameter int LEN_WIDTH         = 16,
    parameter int ENTRY_ADDR_LEN    = 32,
    parameter int NUMBER_MDS        = 2,
    parameter int NUMBER_ENTRIES    = 8,
    parameter int NUMBER_MASTERS    = 2,
    parameter int ENTRIES_PER_CYCLE = 2,
    localparam int TW = $clog2(NUMBER_ENTRIES) + 1,
    localparam int K  = ENTRIES_PER_CYCLE,
    localparam int EW = $clog2(NUMBER_ENTRIES),
    localparam int NG = NUMBER_ENTRIES / ENTRIES_PER_CYCLE,
    localparam int GW = (NG > 1) ? $clog2(NG) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          iopmp_enabled_i,
    input  logic [NUMBER_MDS*TW-1:0]      mdcfg_top_i,
    input  logic [NUMBER_MASTERS*NUMBER_MDS-1:0] srcmd_en_i,
    rv_iopmp_match_engine_if.slave        bus,
    output logic                          rd_en_o,
    output logic [GW-1:0]                 rd_group_o,
    input  logic [K*ENTRY_ADDR_LEN-1:0]   entry_addr_i,
    input  logic [K*8-1:0]                entry_cfg_i
);
    localparam int EAL = ENTRY_ADDR_LEN;
    localparam int NMD = NUMBER_MDS;
    localparam int KW  = $clog2(K);
    localparam int SW  = (K > 1) ? KW : 1;
    localparam int AW1 = ADDR_WIDTH + 1;
    // Comparison width: covers the full request range and the largest NAPOT region.
    localparam int CW  = (AW1 > EAL + 4) ? AW1 : EAL + 4;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [SID_WIDTH-1:0]   sid_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [AW1-1:0]         end_reg;
    logic [1:0]             access_reg;
    logic [NMD*TW-1:0]      top_reg;
    logic [NMD-1:0]         md_en_reg;
    logic [GW-1:0]          last_group_reg;
    logic [GW-1:0]          issue_group_reg, issue_group_next;
    logic                   issuing_reg, issuing_next;
    logic                   eval_valid_reg, eval_valid_next;
    logic [GW-1:0]          eval_group_reg, eval_group_next;
    logic [EAL-1:0]         prev_reg, prev_next;
    logic                   allow_reg, allow_next;
    logic [2:0]             etype_reg, etype_next;
    logic [EW-1:0]          eid_reg, eid_next;
    logic                   err_pulse_reg, err_pulse_next;
    logic                   capture;

    // Request decode
    logic [LEN_WIDTH-1:0]   len_eff;
    logic [AW1-1:0]         req_end;
    logic [NMD-1:0]         req_md_en;
    logic                   sid_ok;
    logic [TW-1:0]          scan_limit;
    logic [GW-1:0]          scan_last;

    // Per-entry evaluation of the group currently on the read port
    logic [K-1:0]           hit_vec, cont_vec, perm_vec;
    logic [TW-1:0]          idx_arr [K];
    logic                   addr_oob;
    logic [CW-1:0]          a_cmp, e_cmp;
    logic                   any_hit;
    logic [SW-1:0]          sel;

    // End address, SID range check and the last group the SID can ever hit.
    always_comb begin
        len_eff   = (bus.req_len_i == '0) ? LEN_WIDTH'(1) : bus.req_len_i;
        req_end   = {1'b0, bus.req_addr_i} + AW1'(len_eff) - AW1'(1);
        sid_ok    = 1'b0;
        req_md_en = '0;
        for (int s = 0; s < NUMBER_MASTERS; s++) begin
            if (bus.req_sid_i == SID_WIDTH'(s)) begin
                sid_ok    = 1'b1;
                req_md_en = srcmd_en_i[s*NMD +: NMD];
            end
        end
        // Tops are non-decreasing, so the highest enabled MD bounds the scan.
        scan_limit = '0;
        for (int m = 0; m < NMD; m++) begin
            if (req_md_en[m]) scan_limit = mdcfg_top_i[m*TW +: TW];
        end
        scan_last = GW'((scan_limit - TW'(1)) >> KW);
    end

    assign addr_oob = |(addr_reg >> (EAL + 2));
    assign a_cmp    = CW'(addr_reg);
    assign e_cmp    = CW'(end_reg);

    for (genvar gi = 0; gi < K; gi++) begin : g_entry
        logic [EAL-1:0] cur;
        logic [EAL-1:0] prv;
        logic [1:0]     amode;
        logic           in_md;
        logic [EAL:0]   napot_mask;
        logic [CW-1:0]  lo, hi;

        assign cur   = entry_addr_i[gi*EAL +: EAL];
        assign amode = entry_cfg_i[gi*8+3 +: 2];
        // TOR lower bound is the preceding entry's field, carried across groups.
        if (gi == 0) begin : g_prev_reg
            assign prv = prev_reg;
        end else begin : g_prev_lane
            assign prv = entry_addr_i[(gi-1)*EAL +: EAL];
        end
        assign idx_arr[gi] = TW'(eval_group_reg) * TW'(K) + TW'(gi);
        // Bits 0..t set, where t is the number of trailing ones in the field.
        assign napot_mask  = {1'b0, cur} ^ ({1'b0, cur} + (EAL+1)'(1));

        // Entry belongs to an MD that is enabled for the captured SID.
        always_comb begin
            logic [TW-1:0] md_lo;
            in_md = 1'b0;
            md_lo = '0;
            for (int m = 0; m < NMD; m++) begin
                if (md_en_reg[m] && idx_arr[gi] >= md_lo && idx_arr[gi] < top_reg[m*TW +: TW])
                    in_md = 1'b1;
                md_lo = top_reg[m*TW +: TW];
            end
        end

        // Half-open byte range [lo, hi) described by the entry.
        always_comb begin
            lo = '0;
            hi = '0;
            case (amode)
                2'd1: begin
                    lo = CW'(prv) << 2;
                    hi = CW'(cur) << 2;
                end
                2'd2: begin
                    lo = CW'(cur) << 2;
                    hi = (CW'(cur) << 2) + CW'(4);
                end
                2'd3: begin
                    lo = CW'({1'b0, cur} & ~napot_mask) << 2;
                    hi = (CW'({1'b0, cur} & ~napot_mask) << 2) + ((CW'(napot_mask) + CW'(1)) << 2);
                end
                default: ;
            endcase
        end

        assign hit_vec[gi]  = in_md && (amode != 2'd0) && !addr_oob &&
                              (lo < hi) && (a_cmp < hi) && (e_cmp >= lo);
        assign cont_vec[gi] = (a_cmp >= lo) && (e_cmp < hi);
        assign perm_vec[gi] = (access_reg == 2'd1) ? entry_cfg_i[gi*8+0] :
                              (access_reg == 2'd2) ? entry_cfg_i[gi*8+1] :
                              (access_reg == 2'd3) ? entry_cfg_i[gi*8+2] : 1'b0;
    end

    // Static priority: lowest lane with a hit decides.
    always_comb begin
        any_hit = |hit_vec;
        sel     = '0;
        for (int j = K - 1; j >= 0; j--) begin
            if (hit_vec[j]) sel = SW'(j);
        end
    end

    // Next-state, read issue and response decision.
    always_comb begin
        state_next       = state_reg;
        issue_group_next = issue_group_reg;
        issuing_next     = issuing_reg;
        eval_valid_next  = 1'b0;
        eval_group_next  = eval_group_reg;
        prev_next        = prev_reg;
        allow_next       = allow_reg;
        etype_next       = etype_reg;
        eid_next         = eid_reg;
        err_pulse_next   = 1'b0;
        capture          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid_i) begin
                    capture          = 1'b1;
                    prev_next        = '0;
                    issue_group_next = '0;
                    eval_group_next  = '0;
                    issuing_next     = 1'b0;
                    allow_next       = 1'b0;
                    eid_next         = '0;
                    if (!iopmp_enabled_i) begin
                        state_next     = RESP;
                        etype_next     = 3'd0;
                        err_pulse_next = 1'b1;
                    end else if (!sid_ok) begin
                        state_next     = RESP;
                        etype_next     = 3'd6;
                        err_pulse_next = 1'b1;
                    end else if (req_end[ADDR_WIDTH]) begin
                        state_next     = RESP;
                        etype_next     = 3'd4;
                        err_pulse_next = 1'b1;
                    end else begin
                        state_next   = SCAN;
                        issuing_next = (scan_limit != '0);
                    end
                end
            end
            SCAN: begin
                if (eval_valid_reg && any_hit) begin
                    state_next   = RESP;
                    issuing_next = 1'b0;
                    eid_next     = EW'(idx_arr[sel]);
                    if (cont_vec[sel] && perm_vec[sel]) begin
                        allow_next = 1'b1;
                        etype_next = 3'd0;
                    end else begin
                        allow_next     = 1'b0;
                        etype_next     = cont_vec[sel] ? {1'b0, access_reg} : 3'd4;
                        err_pulse_next = 1'b1;
                    end
                end else if (!issuing_reg) begin
                    state_next     = RESP;
                    allow_next     = 1'b0;
                    etype_next     = 3'd5;
                    eid_next       = '0;
                    err_pulse_next = 1'b1;
                end else begin
                    eval_valid_next = 1'b1;
                    eval_group_next = issue_group_reg;
                    if (issue_group_reg == last_group_reg) issuing_next = 1'b0;
                    else issue_group_next = issue_group_reg + GW'(1);
                end
                if (eval_valid_reg) prev_next = entry_addr_i[(K-1)*EAL +: EAL];
            end
            RESP: begin
                if (bus.resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            issue_group_reg <= '0;
            issuing_reg     <= 1'b0;
            eval_valid_reg  <= 1'b0;
            eval_group_reg  <= '0;
            prev_reg        <= '0;
            allow_reg       <= 1'b0;
            etype_reg       <= '0;
            eid_reg         <= '0;
            err_pulse_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            issue_group_reg <= issue_group_next;
            issuing_reg     <= issuing_next;
            eval_valid_reg  <= eval_valid_next;
            eval_group_reg  <= eval_group_next;
            prev_reg        <= prev_next;
            allow_reg       <= allow_next;
            etype_reg       <= etype_next;
            eid_reg         <= eid_next;
            err_pulse_reg   <= err_pulse_next;
        end
    end

    // Snapshot of the request and configuration taken on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sid_reg        <= '0;
            addr_reg       <= '0;
            end_reg        <= '0;
            access_reg     <= '0;
            top_reg        <= '0;
            md_en_reg      <= '0;
            last_group_reg <= '0;
        end else if (capture) begin
            sid_reg        <= bus.req_sid_i;
            addr_reg       <= bus.req_addr_i;
            end_reg        <= req_end;
            access_reg     <= bus.req_access_i;
            top_reg        <= mdcfg_top_i;
            md_en_reg      <= req_md_en;
            last_group_reg <= scan_last;
        end
    end

    assign bus.req_ready_o  = (state_reg == IDLE);
    assign bus.resp_valid_o = (state_reg == RESP);
    assign bus.resp_allow_o = (state_reg == RESP) && allow_reg;
    assign bus.resp_etype_o = (state_reg == RESP) ? etype_reg : 3'd0;
    assign bus.resp_eid_o   = (state_reg == RESP) ? eid_reg : '0;
    assign bus.err_valid_o  = err_pulse_reg;
    assign bus.err_sid_o    = err_pulse_reg ? sid_reg : '0;
    assign bus.err_addr_o   = err_pulse_reg ? addr_reg : '0;
    assign rd_en_o          = (state_reg == SCAN) && issuing_reg;
    assign rd_group_o       = rd_en_o ? issue_group_reg : '0;

    // Reserved cfg bits carry no meaning for matching.
    logic unused_cfg_bits;
    always_comb begin
        unused_cfg_bits = 1'b0;
        for (int j = 0; j < K; j++) unused_cfg_bits = unused_cfg_bits ^ (^entry_cfg_i[j*8+5 +: 3]);
    end
endmodule

// File: tb/tb_rv_iopmp_match_engine.sv
// Directed bench for rv_iopmp_match_engine: hand-computed allow/deny,
// error type, deciding entry and latency for each scenario.
module tb_rv_iopmp_match_engine;
    localparam int AW = 64, SW = 8, LW = 16, EAL = 32, NMD = 2, NE = 8, NM = 2, K = 2;
    localparam int TW = 4, EW = 3, GW = 2;

    logic                   clk_i  = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   iopmp_enabled_i;
    logic [NMD*TW-1:0]      mdcfg_top_i;
    logic [NM*NMD-1:0]      srcmd_en_i;
    logic                   rd_en_o;
    logic [GW-1:0]          rd_group_o;
    logic [K*EAL-1:0]       entry_addr_i;
    logic [K*8-1:0]         entry_cfg_i;

    logic [EAL-1:0]         tbl_addr [NE];
    logic [7:0]             tbl_cfg  [NE];

    int n_checks = 0;
    int n_fail   = 0;

    rv_iopmp_match_engine_if #(.ADDR_WIDTH(AW), .SID_WIDTH(SW), .LEN_WIDTH(LW), .EID_WIDTH(EW)) bus ();

    rv_iopmp_match_engine #(
        .ADDR_WIDTH(AW), .SID_WIDTH(SW), .LEN_WIDTH(LW), .ENTRY_ADDR_LEN(EAL),
        .NUMBER_MDS(NMD), .NUMBER_ENTRIES(NE), .NUMBER_MASTERS(NM), .ENTRIES_PER_CYCLE(K)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .iopmp_enabled_i(iopmp_enabled_i),
        .mdcfg_top_i(mdcfg_top_i), .srcmd_en_i(srcmd_en_i), .bus(bus),
        .rd_en_o(rd_en_o), .rd_group_o(rd_group_o),
        .entry_addr_i(entry_addr_i), .entry_cfg_i(entry_cfg_i)
    );

    always #5 clk_i = ~clk_i;

    // Entry table with a registered read: data appears the cycle after rd_en_o.
    always @(posedge clk_i) begin
        if (rd_en_o) begin
            for (int j = 0; j < K; j++) begin
                entry_addr_i[j*EAL +: EAL] <= tbl_addr[int'(rd_group_o)*K + j];
                entry_cfg_i[j*8 +: 8]      <= tbl_cfg[int'(rd_group_o)*K + j];
            end
        end
    end

    task automatic clear_table();
        for (int i = 0; i < NE; i++) begin
            tbl_addr[i] = '0;
            tbl_cfg[i]  = '0;
        end
    endtask

    // Issue one request; returns once resp_valid_o is seen (or the bound expires).
    // lat = number of clock edges from the accepting edge until the response is visible.
    task automatic do_req(input logic [SW-1:0] sid, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, input logic [1:0] acc,
                          output int lat, output logic rd1, output logic [GW-1:0] grp1);
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_sid_i    = sid;
        bus.req_addr_i   = addr;
        bus.req_len_i    = len;
        bus.req_access_i = acc;
        @(posedge clk_i);
        #1 bus.req_valid_i = 1'b0;
        lat = 1;
        @(negedge clk_i);
        rd1  = rd_en_o;
        grp1 = rd_group_o;
        while (!bus.resp_valid_o && lat < 40) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        $display("txn sid=%0d addr=%h len=%0d acc=%0d -> valid=%0b allow=%0b etype=%0d eid=%0d err=%0b lat=%0d",
                 sid, addr, len, acc, bus.resp_valid_o, bus.resp_allow_o, bus.resp_etype_o,
                 bus.resp_eid_o, bus.err_valid_o, lat);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
        end while (!bus.req_ready_o && n < 20);
    endtask

    task automatic test_reset();
        iopmp_enabled_i  = 1'b1;
        mdcfg_top_i      = {4'd8, 4'd4};
        srcmd_en_i       = 4'b1001;
        bus.req_valid_i  = 1'b0;
        bus.req_sid_i    = '0;
        bus.req_addr_i   = '0;
        bus.req_len_i    = '0;
        bus.req_access_i = '0;
        bus.resp_ready_i = 1'b1;
        entry_addr_i     = '0;
        entry_cfg_i      = '0;
        clear_table();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready_o); end
        n_checks++;
        if ({bus.resp_valid_o, bus.resp_allow_o, bus.resp_etype_o, bus.resp_eid_o} !== 8'd0) begin
            n_fail++; $display("FAIL reset_resp: got v=%b a=%b et=%0d eid=%0d expected all 0",
                               bus.resp_valid_o, bus.resp_allow_o, bus.resp_etype_o, bus.resp_eid_o);
        end
        n_checks++;
        if ({rd_en_o, bus.err_valid_o} !== 2'b00 || bus.err_addr_o !== 64'd0 || bus.err_sid_o !== 8'd0) begin
            n_fail++; $display("FAIL reset_misc: got rd_en=%b err=%b expected 0", rd_en_o, bus.err_valid_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_allow_na4();
        int lat; logic rd1; logic [GW-1:0] grp1;
        clear_table();
        tbl_addr[0] = 32'h400; tbl_cfg[0] = 8'h11;           // NA4, R
        srcmd_en_i  = 4'b1001;
        do_req(8'd0, 64'h1000, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (rd1 !== 1'b1 || grp1 !== 2'd0) begin n_fail++; $display("FAIL na4_rd_t1: got rd_en=%b group=%0d expected 1/0", rd1, grp1); end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL na4_latency: got %0d expected 3", lat); end
        n_checks++;
        if (bus.resp_allow_o !== 1'b1 || bus.resp_eid_o !== 3'd0 || bus.resp_etype_o !== 3'd0) begin
            n_fail++; $display("FAIL na4_result: got allow=%b eid=%0d etype=%0d expected 1/0/0",
                               bus.resp_allow_o, bus.resp_eid_o, bus.resp_etype_o);
        end
        n_checks++;
        if (bus.err_valid_o !== 1'b0) begin n_fail++; $display("FAIL na4_no_err: got %b expected 0", bus.err_valid_o); end
        n_checks++;
        if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL na4_ready_in_resp: got %b expected 0", bus.req_ready_o); end
        wait_idle();
        // Zero length is a single byte: [0x1000,0x1000] lies inside the NA4 region.
        do_req(8'd0, 64'h1000, 16'd0, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_allow_o !== 1'b1 || lat !== 3) begin
            n_fail++; $display("FAIL len0_allow: got allow=%b lat=%0d expected 1/3", bus.resp_allow_o, lat);
        end
        wait_idle();
    endtask

    task automatic test_tor_priority();
        int lat; logic rd1; logic [GW-1:0] grp1;
        clear_table();
        tbl_addr[4] = 32'h400;                               // OFF, only feeds TOR base
        tbl_addr[5] = 32'h800; tbl_cfg[5] = 8'h0A;           // TOR, W -> [0x1000,0x2000)
        srcmd_en_i  = 4'b1011;                               // SID0 sees MD0 and MD1
        do_req(8'd0, 64'h1800, 16'd8, 2'd2, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_allow_o !== 1'b1 || bus.resp_eid_o !== 3'd5) begin
            n_fail++; $display("FAIL tor_result: got allow=%b eid=%0d expected 1/5", bus.resp_allow_o, bus.resp_eid_o);
        end
        // Group 2 data is evaluated at T+4, response registered one edge later.
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL tor_latency: got %0d expected 5", lat); end
        wait_idle();
        // TOR base carried across a group boundary: entry 3 field bounds entry 4.
        clear_table();
        tbl_addr[3] = 32'h300;
        tbl_addr[4] = 32'h400; tbl_cfg[4] = 8'h09;           // TOR, R -> [0xC00,0x1000)
        do_req(8'd0, 64'hC00, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_allow_o !== 1'b1 || bus.resp_eid_o !== 3'd4 || lat !== 5) begin
            n_fail++; $display("FAIL tor_carry: got allow=%b eid=%0d lat=%0d expected 1/4/5",
                               bus.resp_allow_o, bus.resp_eid_o, lat);
        end
        wait_idle();
    endtask

    task automatic test_perm_partial();
        int lat; logic rd1; logic [GW-1:0] grp1;
        clear_table();
        tbl_addr[2] = 32'h9FF; tbl_cfg[2] = 8'h19;           // NAPOT 0x2000-0x2FFF, R
        srcmd_en_i  = 4'b1001;
        do_req(8'd0, 64'h2100, 16'd4, 2'd2, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_allow_o !== 1'b0 || bus.resp_etype_o !== 3'd2 || bus.resp_eid_o !== 3'd2 || lat !== 4) begin
            n_fail++; $display("FAIL perm_write: got allow=%b etype=%0d eid=%0d lat=%0d expected 0/2/2/4",
                               bus.resp_allow_o, bus.resp_etype_o, bus.resp_eid_o, lat);
        end
        n_checks++;
        if (bus.err_valid_o !== 1'b1 || bus.err_addr_o !== 64'h2100 || bus.err_sid_o !== 8'd0) begin
            n_fail++; $display("FAIL perm_err: got v=%b addr=%h sid=%0d expected 1/2100/0",
                               bus.err_valid_o, bus.err_addr_o, bus.err_sid_o);
        end
        wait_idle();
        n_checks++;
        if (bus.err_valid_o !== 1'b0 || bus.err_addr_o !== 64'd0) begin
            n_fail++; $display("FAIL err_clears: got v=%b addr=%h expected 0/0", bus.err_valid_o, bus.err_addr_o);
        end
        do_req(8'd0, 64'h2FFE, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_allow_o !== 1'b0 || bus.resp_etype_o !== 3'd4 || bus.resp_eid_o !== 3'd2) begin
            n_fail++; $display("FAIL partial: got allow=%b etype=%0d eid=%0d expected 0/4/2",
                               bus.resp_allow_o, bus.resp_etype_o, bus.resp_eid_o);
        end
        n_checks++;
        if (bus.err_valid_o !== 1'b1 || bus.err_addr_o !== 64'h2FFE) begin
            n_fail++; $display("FAIL partial_err: got v=%b addr=%h expected 1/2ffe", bus.err_valid_o, bus.err_addr_o);
        end
        wait_idle();
    endtask

    task automatic test_md_mask();
        int lat; logic rd1; logic [GW-1:0] grp1;
        // Same NAPOT entry 2 (MD0); SID1 only sees MD1 -> nothing matches.
        do_req(8'd1, 64'h2100, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_allow_o !== 1'b0 || bus.resp_etype_o !== 3'd5 || bus.resp_eid_o !== 3'd0) begin
            n_fail++; $display("FAIL md_mask: got allow=%b etype=%0d eid=%0d expected 0/5/0",
                               bus.resp_allow_o, bus.resp_etype_o, bus.resp_eid_o);
        end
        // Four groups read at T+1..T+4, last evaluated at T+5, response at T+6.
        n_checks++;
        if (lat !== 6 || bus.err_sid_o !== 8'd1) begin
            n_fail++; $display("FAIL md_mask_timing: got lat=%0d err_sid=%0d expected 6/1", lat, bus.err_sid_o);
        end
        wait_idle();
        do_req(8'd2, 64'h2100, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_etype_o !== 3'd6 || bus.resp_allow_o !== 1'b0 || lat !== 1 || bus.err_sid_o !== 8'd2) begin
            n_fail++; $display("FAIL bad_sid: got etype=%0d allow=%b lat=%0d err_sid=%0d expected 6/0/1/2",
                               bus.resp_etype_o, bus.resp_allow_o, lat, bus.err_sid_o);
        end
        wait_idle();
        iopmp_enabled_i = 1'b0;
        do_req(8'd0, 64'h2100, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_etype_o !== 3'd0 || bus.resp_allow_o !== 1'b0 || lat !== 1 || bus.err_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL disabled: got etype=%0d allow=%b lat=%0d err=%b expected 0/0/1/1",
                               bus.resp_etype_o, bus.resp_allow_o, lat, bus.err_valid_o);
        end
        wait_idle();
        iopmp_enabled_i = 1'b1;
    endtask

    task automatic test_length_edge();
        int lat; logic rd1; logic [GW-1:0] grp1;
        do_req(8'd0, 64'hFFFF_FFFF_FFFF_FFFE, 16'd4, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_etype_o !== 3'd4 || bus.resp_eid_o !== 3'd0 || bus.resp_allow_o !== 1'b0 || lat !== 1) begin
            n_fail++; $display("FAIL overflow: got etype=%0d eid=%0d allow=%b lat=%0d expected 4/0/0/1",
                               bus.resp_etype_o, bus.resp_eid_o, bus.resp_allow_o, lat);
        end
        n_checks++;
        if (bus.err_addr_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++; $display("FAIL overflow_err_addr: got %h expected fffffffffffffffe", bus.err_addr_o);
        end
        wait_idle();
        // Ends exactly at 2^64-1: no overflow, but high address bits exclude every entry.
        do_req(8'd0, 64'hFFFF_FFFF_FFFF_FFFE, 16'd2, 2'd1, lat, rd1, grp1);
        n_checks++;
        if (bus.resp_etype_o !== 3'd5 || lat !== 4) begin
            n_fail++; $display("FAIL top_no_overflow: got etype=%0d lat=%0d expected 5/4", bus.resp_etype_o, lat);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int lat; logic rd1; logic [GW-1:0] grp1; int bad;
        bus.resp_ready_i = 1'b0;
        do_req(8'd0, 64'h2100, 16'd4, 2'd2, lat, rd1, grp1);  // NAPOT R-only, write -> etype 2
        n_checks++;
        if (bus.err_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_err: got %b expected 1", bus.err_valid_o); end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (bus.resp_valid_o !== 1'b1 || bus.resp_etype_o !== 3'd2 || bus.resp_eid_o !== 3'd2 ||
                bus.resp_allow_o !== 1'b0 || bus.req_ready_o !== 1'b0 || bus.err_valid_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        bus.resp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", bus.resp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_sid_i    = 8'd1;
        bus.req_addr_i   = 64'h2100;
        bus.req_len_i    = 16'd4;
        bus.req_access_i = 2'd1;
        @(posedge clk_i);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        $display("txn reset mid-scan -> ready=%0b valid=%0b rd_en=%0b", bus.req_ready_o, bus.resp_valid_o, rd_en_o);
        n_checks++;
        if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0 || rd_en_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_scan: got ready=%b valid=%b rd_en=%b expected 1/0/0",
                               bus.req_ready_o, bus.resp_valid_o, rd_en_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (bus.resp_valid_o || bus.err_valid_o || !bus.req_ready_o) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d cycles with activity expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat; logic rd1; logic [GW-1:0] grp1;
        clear_table();
        tbl_addr[0] = 32'h400; tbl_cfg[0] = 8'h11;
        do_req(8'd0, 64'h1000, 16'd4, 2'd1, lat, rd1, grp1);
        do_req(8'd0, 64'h1004, 16'd4, 2'd1, lat, rd1, grp1);  // just past the NA4 word
        n_checks++;
        if (bus.resp_allow_o !== 1'b0 || bus.resp_etype_o !== 3'd5 || lat !== 4) begin
            n_fail++; $display("FAIL back_to_back: got allow=%b etype=%0d lat=%0d expected 0/5/4",
                               bus.resp_allow_o, bus.resp_etype_o, lat);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_allow_na4();
        test_tor_priority();
        test_perm_partial();
        test_md_mask();
        clear_table();
        tbl_addr[0] = 32'h400; tbl_cfg[0] = 8'h11;
        test_length_edge();
        clear_table();
        tbl_addr[2] = 32'h9FF; tbl_cfg[2] = 8'h19;
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
